// File: rtl/pulse_train_scheduler.sv
// Queues pulse descriptors and fires the selected signal generator REPEAT times,
// with a programmable idle gap after each pulse.
//
// state    | meaning
// IDLE     | no descriptor active; pops the FIFO head when ENABLE is high
// LOAD     | drives SIGNAL_TYPE/T_IMPULSE from the working descriptor
// ARM      | waits for ENABLE && OUT_REG_READY before requesting a pulse
// WAIT_ACK | SIGN_START_GEN held high until the generator acknowledges
// RUN      | pulse in flight; waits for the generator's last-sample flag
// GAP      | gap+1 idle cycles, then next repeat (ARM) or IDLE
module pulse_train_scheduler #(
  parameter int          _FIFO_DEPTH  = 4,
  parameter int          _FIFO_AW     = 2,
  parameter logic [15:0] _ACK_TIMEOUT = 16'd255,
  parameter int          _GAP_W       = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CFG_WR,
  input  logic [1:0]        CFG_SIGNAL_TYPE,
  input  logic [9:0]        CFG_T_IMPULSE,
  input  logic [_GAP_W-1:0] CFG_GAP,
  input  logic [7:0]        CFG_REPEAT,
  output logic              CFG_FULL,
  input  logic              ENABLE,
  input  logic              OUT_REG_READY,
  input  logic              SIGN_START_CALC,
  input  logic              SIGN_STOP_CALC,
  output logic [1:0]        SIGNAL_TYPE,
  output logic [9:0]        T_IMPULSE,
  output logic              SIGN_START_GEN,
  output logic              BUSY,
  output logic              PULSE_DONE,
  output logic              ERR_TIMEOUT
);

  localparam int                DESC_W   = 2 + 10 + _GAP_W + 8;
  localparam logic [_FIFO_AW:0] FULL_CNT = _FIFO_DEPTH[_FIFO_AW:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_WAIT_ACK,
    S_RUN,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic [DESC_W-1:0]   fifo_mem [_FIFO_DEPTH];
  logic [_FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [_FIFO_AW:0]   fifo_cnt, fifo_cnt_d;
  logic [DESC_W-1:0]   head;
  logic [1:0]          h_type;
  logic [9:0]          h_t;
  logic [_GAP_W-1:0]   h_gap;
  logic [7:0]          h_rep;

  logic [1:0]          w_type;
  logic [9:0]          w_t;
  logic [_GAP_W-1:0]   w_gap;
  logic [7:0]          rep_cnt;
  logic [_GAP_W-1:0]   gap_cnt;
  logic [15:0]         tmo_cnt;

  logic push, pop, fire, finish, tmo;

  assign push = CFG_WR && !CFG_FULL;
  assign head = fifo_mem[rd_ptr];
  assign {h_type, h_t, h_gap, h_rep} = head;
  assign BUSY = (state_q != S_IDLE);

  always_comb begin
    fifo_cnt_d = fifo_cnt;
    if (push && !pop)
      fifo_cnt_d = fifo_cnt + 1'b1;
    else if (!push && pop)
      fifo_cnt_d = fifo_cnt - 1'b1;
  end

  // Descriptor storage needs no reset: emptiness is tracked by the count alone.
  always_ff @(posedge CLK) begin
    if (push)
      fifo_mem[wr_ptr] <= {CFG_SIGNAL_TYPE, CFG_T_IMPULSE, CFG_GAP, CFG_REPEAT};
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      CFG_FULL <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt_d;
      CFG_FULL <= (fifo_cnt_d == FULL_CNT);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fire    = 1'b0;
    finish  = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ENABLE && (fifo_cnt != '0)) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_ARM;
      S_ARM: begin
        if (ENABLE && OUT_REG_READY) begin
          fire    = 1'b1;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // A generator that starts and ends in the same cycle counts as a completed pulse.
        if (SIGN_START_CALC && SIGN_STOP_CALC) begin
          finish  = 1'b1;
          state_d = S_GAP;
        end else if (SIGN_START_CALC) begin
          state_d = S_RUN;
        end else if (tmo_cnt <= 16'd1) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (SIGN_STOP_CALC) begin
          finish  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0)
          state_d = (rep_cnt != 8'd0) ? S_ARM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      w_type         <= '0;
      w_t            <= '0;
      w_gap          <= '0;
      rep_cnt        <= '0;
      gap_cnt        <= '0;
      tmo_cnt        <= '0;
      SIGNAL_TYPE    <= '0;
      T_IMPULSE      <= '0;
      SIGN_START_GEN <= 1'b0;
      PULSE_DONE     <= 1'b0;
      ERR_TIMEOUT    <= 1'b0;
    end else begin
      if (pop) begin
        w_type  <= h_type;
        w_t     <= h_t;
        w_gap   <= h_gap;
        rep_cnt <= (h_rep == 8'd0) ? 8'd1 : h_rep;
      end else if (finish) begin
        rep_cnt <= rep_cnt - 8'd1;
      end
      if (state_q == S_LOAD) begin
        SIGNAL_TYPE <= w_type;
        T_IMPULSE   <= w_t;
      end
      // Ack timeout counts down from _ACK_TIMEOUT; expiry is the terminal count of 1.
      if (fire)
        tmo_cnt <= _ACK_TIMEOUT;
      else if ((state_q == S_WAIT_ACK) && (tmo_cnt != 16'd0))
        tmo_cnt <= tmo_cnt - 16'd1;
      if (finish)
        gap_cnt <= w_gap;
      else if ((state_q == S_GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - 1'b1;
      SIGN_START_GEN <= (state_d == S_WAIT_ACK);
      PULSE_DONE     <= finish;
      if (tmo)
        ERR_TIMEOUT <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pulse_train_scheduler.sv
// Self-checking bench for pulse_train_scheduler: an event/timestamp model of the
// descriptor schedule checked every cycle, plus hand-computed timing points.
module tb_pulse_train_scheduler;

  localparam int ACK_TMO = 255;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        CFG_WR = 1'b0;
  logic [1:0]  CFG_SIGNAL_TYPE = '0;
  logic [9:0]  CFG_T_IMPULSE = '0;
  logic [15:0] CFG_GAP = '0;
  logic [7:0]  CFG_REPEAT = '0;
  logic        CFG_FULL;
  logic        ENABLE = 1'b1;
  logic        OUT_REG_READY = 1'b1;
  logic        SIGN_START_CALC;
  logic        SIGN_STOP_CALC;
  logic [1:0]  SIGNAL_TYPE;
  logic [9:0]  T_IMPULSE;
  logic        SIGN_START_GEN;
  logic        BUSY;
  logic        PULSE_DONE;
  logic        ERR_TIMEOUT;

  logic sc_rsp = 1'b0, ss_rsp = 1'b0, sc_stray = 1'b0, ss_stray = 1'b0;
  assign SIGN_START_CALC = sc_rsp | sc_stray;
  assign SIGN_STOP_CALC  = ss_rsp | ss_stray;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  pulse_train_scheduler dut (
    .CLK(CLK), .RESET(RESET), .CFG_WR(CFG_WR), .CFG_SIGNAL_TYPE(CFG_SIGNAL_TYPE),
    .CFG_T_IMPULSE(CFG_T_IMPULSE), .CFG_GAP(CFG_GAP), .CFG_REPEAT(CFG_REPEAT),
    .CFG_FULL(CFG_FULL), .ENABLE(ENABLE), .OUT_REG_READY(OUT_REG_READY),
    .SIGN_START_CALC(SIGN_START_CALC), .SIGN_STOP_CALC(SIGN_STOP_CALC),
    .SIGNAL_TYPE(SIGNAL_TYPE), .T_IMPULSE(T_IMPULSE), .SIGN_START_GEN(SIGN_START_GEN),
    .BUSY(BUSY), .PULSE_DONE(PULSE_DONE), .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Generator stand-in: acks ack_dly cycles after the request, last sample stop_dly later.
  int ack_dly = 2, stop_dly = 10;
  bit ack_en = 1'b1, both_mode = 1'b0;
  int r_st = 0, r_age = 0;
  always @(negedge CLK) begin
    sc_rsp = 1'b0;
    ss_rsp = 1'b0;
    if (!RESET) begin
      r_st = 0;
    end else begin
      if (r_st == 0 && SIGN_START_GEN) begin
        r_st  = 1;
        r_age = 0;
      end
      if (r_st == 1) begin
        r_age++;
        if (!SIGN_START_GEN) r_st = 0;
        else if (ack_en && r_age == ack_dly) begin
          sc_rsp = 1'b1;
          if (both_mode) begin
            ss_rsp = 1'b1;
            r_st   = 0;
          end else begin
            r_st  = 2;
            r_age = 0;
          end
        end
      end else if (r_st == 2) begin
        r_age++;
        if (r_age == stop_dly) begin
          ss_rsp = 1'b1;
          r_st   = 0;
        end
      end
    end
  end

  // Reference: a queue of descriptors and edge timestamps for when each action may happen.
  typedef struct { int typ; int t; int gap; int rep; } desc_t;
  desc_t mq[$];
  desc_t mcur;
  int   n_edge = 0;
  bit   m_active = 0, m_gen = 0, m_done = 0, m_err = 0, m_full = 0;
  logic [1:0] m_type = '0;
  logic [9:0] m_t = '0;
  int   m_phase = 0, m_reps = 0, m_fire_from = 0, m_load_at = -1, m_idle_at = -1, m_gen_since = 0;
  bit   m_push, m_fin;

  always @(posedge CLK) begin
    n_edge++;
    if (!RESET) begin
      mq.delete();
      m_active = 0; m_gen = 0; m_done = 0; m_err = 0; m_full = 0;
      m_type = '0; m_t = '0; m_phase = 0; m_reps = 0; m_load_at = -1; m_idle_at = -1;
    end else begin
      m_push = CFG_WR && !m_full;
      m_done = 0;
      if (m_active) begin
        if (n_edge == m_load_at) begin
          m_type = mcur.typ[1:0];
          m_t    = mcur.t[9:0];
        end
        m_fin = (m_phase == 1 && SIGN_START_CALC && SIGN_STOP_CALC) || (m_phase == 2 && SIGN_STOP_CALC);
        if (m_fin) begin
          m_done = 1; m_gen = 0; m_phase = 0; m_reps--;
          m_fire_from = n_edge + mcur.gap + 2;
          m_idle_at   = n_edge + mcur.gap + 1;
        end else if (m_phase == 0) begin
          if (m_reps > 0 && n_edge >= m_fire_from && ENABLE && OUT_REG_READY) begin
            m_gen = 1; m_phase = 1; m_gen_since = n_edge;
          end else if (m_reps == 0 && n_edge == m_idle_at) begin
            m_active = 0;
          end
        end else if (m_phase == 1) begin
          if (SIGN_START_CALC) begin
            m_gen = 0; m_phase = 2;
          end else if (n_edge - m_gen_since == ACK_TMO) begin
            m_gen = 0; m_err = 1; m_active = 0; m_phase = 0;
          end
        end
      end else if (ENABLE && mq.size() > 0) begin
        mcur = mq.pop_front();
        m_reps = (mcur.rep == 0) ? 1 : mcur.rep;
        m_active = 1; m_phase = 0;
        m_load_at = n_edge + 1;
        m_fire_from = n_edge + 2;
      end
      if (m_push) mq.push_back('{int'(CFG_SIGNAL_TYPE), int'(CFG_T_IMPULSE), int'(CFG_GAP), int'(CFG_REPEAT)});
      m_full = (mq.size() == 4);
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("cyc_type", SIGNAL_TYPE, m_type);
      chk("cyc_timp", T_IMPULSE, m_t);
      chk("cyc_gen", SIGN_START_GEN, m_gen);
      chk("cyc_done", PULSE_DONE, m_done);
      chk("cyc_err", ERR_TIMEOUT, m_err);
      chk("cyc_busy", BUSY, m_active);
      chk("cyc_full", CFG_FULL, m_full);
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic push(input int typ, input int t, input int gap, input int rep);
    CFG_SIGNAL_TYPE = typ[1:0];
    CFG_T_IMPULSE   = t[9:0];
    CFG_GAP         = gap[15:0];
    CFG_REPEAT      = rep[7:0];
    CFG_WR = 1'b1;
    tick();
    CFG_WR = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while (BUSY && k < maxc) begin tick(); k++; end
    chk("idle_reached", BUSY, 0);
  endtask

  task automatic wait_gen(input logic lvl, input int maxc);
    int k = 0;
    while (SIGN_START_GEN !== lvl && k < maxc) begin tick(); k++; end
    chk("gen_level_reached", SIGN_START_GEN, lvl);
  endtask

  // Single pulse {type 3, T 60, gap 0, repeat 1}; negedge k follows the k-th edge after the write.
  task automatic run_s1();
    push(3, 60, 0, 1);
    chk("s1_busy0", BUSY, 0);
    tick();
    chk("s1_gen1", SIGN_START_GEN, 0);
    chk("s1_busy1", BUSY, 1);
    tick(); tick();
    chk("s1_gen3", SIGN_START_GEN, 1);
    chk("s1_model_gen3", m_gen, 1);
    chk("s1_type", SIGNAL_TYPE, 3);
    chk("s1_timp", T_IMPULSE, 60);
    chk("s1_model_timp", m_t, 60);
    tick();
    chk("s1_gen4", SIGN_START_GEN, 1);
    tick();
    chk("s1_gen5", SIGN_START_GEN, 0);
    chk("s1_model_gen5", m_gen, 0);
    repeat (9) tick();
    chk("s1_done14", PULSE_DONE, 0);
    tick();
    chk("s1_done15", PULSE_DONE, 1);
    chk("s1_model_done15", m_done, 1);
    tick();
    chk("s1_done16", PULSE_DONE, 0);
    chk("s1_busy16", BUSY, 0);
    chk("s1_model_busy16", m_active, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, prev, mprev, rises, mrises, dones, mdones, last_d, k, nr;
    int typs[4];
    int ts[4];
    RESET = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    chk("rst_gen", SIGN_START_GEN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_full", CFG_FULL, 0);
    chk("rst_err", ERR_TIMEOUT, 0);
    RESET = 1'b1;
    tick();

    run_s1();

    // Repeat 3 with gap 5: next request 7 edges after each completion edge.
    push(1, 100, 5, 3);
    cyc = 0; prev = 0; mprev = 0; rises = 0; mrises = 0; dones = 0; mdones = 0; last_d = -100;
    while (dones < 3 && cyc < 400) begin
      tick(); cyc++;
      if (SIGN_START_GEN && !prev) begin
        rises++;
        if (rises > 1) chk("train_spacing", cyc - last_d, 7);
      end
      if (m_gen && !mprev) mrises++;
      prev = SIGN_START_GEN; mprev = m_gen;
      if (PULSE_DONE) begin dones++; last_d = cyc; end
      if (m_done) mdones++;
    end
    chk("train_dones", dones, 3);
    chk("train_rises", rises, 3);
    chk("train_model_dones", mdones, 3);
    chk("train_model_rises", mrises, 3);
    wait_idle(20);

    // Missing ack: timeout aborts the rest of the train, next descriptor still runs.
    ack_en = 1'b0;
    push(2, 5, 0, 2);
    push(0, 7, 1, 1);
    wait_gen(1'b1, 20);
    k = 0;
    while (SIGN_START_GEN && k < 400) begin tick(); k++; end
    chk("tmo_len", k, 255);
    chk("tmo_err", ERR_TIMEOUT, 1);
    chk("tmo_model_err", m_err, 1);
    ack_en = 1'b1;
    k = 0;
    while (!PULSE_DONE && k < 100) begin tick(); k++; end
    chk("tmo_next_done", PULSE_DONE, 1);
    chk("tmo_next_type", SIGNAL_TYPE, 0);
    chk("tmo_next_timp", T_IMPULSE, 7);
    wait_idle(20);
    chk("tmo_err_sticky", ERR_TIMEOUT, 1);
    RESET = 1'b0;
    tick();
    chk("tmo_err_cleared", ERR_TIMEOUT, 0);
    RESET = 1'b1;
    tick();

    // Fill with ENABLE low: 4 accepted, 5th dropped, executed in order.
    ENABLE = 1'b0;
    push(0, 10, 2, 1);
    push(1, 20, 2, 1);
    push(2, 30, 2, 1);
    chk("full_after3", CFG_FULL, 0);
    push(3, 40, 2, 1);
    chk("full_after4", CFG_FULL, 1);
    chk("full_model_after4", m_full, 1);
    push(1, 500, 2, 1);
    chk("full_after5", CFG_FULL, 1);
    ENABLE = 1'b1;
    nr = 0; prev = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (SIGN_START_GEN && !prev) begin
        if (nr < 4) begin typs[nr] = SIGNAL_TYPE; ts[nr] = T_IMPULSE; end
        nr++;
      end
      prev = SIGN_START_GEN;
    end
    chk("order_count", nr, 4);
    for (int i = 0; i < 4; i++) begin
      chk("order_type", typs[i], i);
      chk("order_timp", ts[i], (i + 1) * 10);
    end
    chk("order_idle", BUSY, 0);

    // Output register not ready: hold in ARM (strays ignored), fire the cycle after ready.
    OUT_REG_READY = 1'b0;
    push(2, 33, 1, 1);
    repeat (20) tick();
    sc_stray = 1'b1; tick(); sc_stray = 1'b0;
    ss_stray = 1'b1; tick(); ss_stray = 1'b0;
    chk("rdy_hold_gen", SIGN_START_GEN, 0);
    chk("rdy_hold_busy", BUSY, 1);
    OUT_REG_READY = 1'b1;
    tick();
    chk("rdy_gen", SIGN_START_GEN, 1);
    chk("rdy_model_gen", m_gen, 1);
    wait_idle(60);

    // Stray handshakes while idle.
    sc_stray = 1'b1; ss_stray = 1'b1;
    tick(); tick();
    sc_stray = 1'b0; ss_stray = 1'b0;
    tick();
    chk("stray_busy", BUSY, 0);
    chk("stray_done", PULSE_DONE, 0);

    // ENABLE dropped mid-train: pulse and gap finish, second repeat waits.
    push(1, 44, 3, 2);
    wait_gen(1'b1, 20);
    ENABLE = 1'b0;
    repeat (40) tick();
    chk("en_hold_busy", BUSY, 1);
    chk("en_hold_gen", SIGN_START_GEN, 0);
    ENABLE = 1'b1;
    wait_gen(1'b1, 10);
    wait_idle(60);

    // Ack and last-sample in the same cycle complete the pulse.
    both_mode = 1'b1;
    push(2, 9, 0, 1);
    wait_gen(1'b1, 10);
    tick(); tick();
    chk("both_done", PULSE_DONE, 1);
    chk("both_gen", SIGN_START_GEN, 0);
    wait_idle(10);
    both_mode = 1'b0;

    // Reset during RUN with a second descriptor queued.
    push(1, 50, 0, 1);
    push(2, 51, 0, 1);
    wait_gen(1'b1, 10);
    wait_gen(1'b0, 10);
    tick(); tick();
    RESET = 1'b0;
    tick();
    chk("rrun_gen", SIGN_START_GEN, 0);
    chk("rrun_busy", BUSY, 0);
    chk("rrun_type", SIGNAL_TYPE, 0);
    chk("rrun_timp", T_IMPULSE, 0);
    chk("rrun_done", PULSE_DONE, 0);
    chk("rrun_full", CFG_FULL, 0);
    RESET = 1'b1;
    repeat (6) tick();
    chk("rrun_fifo_empty", BUSY, 0);

    // Reset during WAIT_ACK drops the request at that edge.
    ack_dly = 6;
    push(3, 61, 0, 1);
    wait_gen(1'b1, 10);
    tick();
    RESET = 1'b0;
    tick();
    chk("rwa_gen", SIGN_START_GEN, 0);
    chk("rwa_busy", BUSY, 0);
    RESET = 1'b1;
    ack_dly = 2;
    tick();
    run_s1();

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_train_scheduler.md
Name: pulse_train_scheduler

Overview:
Sequences the signal generators (noise, LFM, etc.) that share the output register. It holds a small FIFO of pulse descriptors and, for each descriptor, fires the selected generator the configured number of times with a programmable inter-pulse gap. It drives the generators' SIGNAL_TYPE, T_IMPULSE and SIGN_START_GEN. It consumes the generators' SIGN_START_CALC and SIGN_STOP_CALC and the output register's OUT_REG_READY.

Parameters:
_FIFO_DEPTH, 4, descriptor FIFO depth (power of 2)
_FIFO_AW, 2, log2(_FIFO_DEPTH)
_ACK_TIMEOUT, 16'd255, max cycles in WAIT_ACK before abort
_GAP_W, 16, width of the gap field and gap counter

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-low reset
CFG_WR  in  1  push descriptor (ignored while CFG_FULL=1)
CFG_SIGNAL_TYPE  in  2  generator select
CFG_T_IMPULSE  in  10  pulse length in us
CFG_GAP  in  _GAP_W  idle cycles after each pulse
CFG_REPEAT  in  8  pulses per descriptor; 0 is treated as 1
CFG_FULL  out  1  FIFO full
ENABLE  in  1  permits starting new pulses
OUT_REG_READY  in  1  output register ready
SIGN_START_CALC  in  1  OR of generator start acks
SIGN_STOP_CALC  in  1  OR of generator last-sample flags
SIGNAL_TYPE  out  2  to generators
T_IMPULSE  out  10  to generators
SIGN_START_GEN  out  1  start request
BUSY  out  1  state != IDLE
PULSE_DONE  out  1  one-cycle strobe per completed pulse
ERR_TIMEOUT  out  1  sticky ack-timeout flag

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - State goes to IDLE, the FIFO is emptied and all counters clear.
  - All outputs go to 0, including ERR_TIMEOUT.
  - Reset applied mid-pulse drops SIGN_START_GEN at that same edge.
- FIFO:
  - Registered push on CFG_WR && !CFG_FULL; a write while full is dropped, even if a pop occurs in the same cycle.
  - A pop happens only in IDLE->LOAD.
  - Pointers wrap modulo _FIFO_DEPTH; a count register of _FIFO_AW+1 bits drives CFG_FULL.
- IDLE: if ENABLE && FIFO non-empty, pop the head into working registers. Set rep_cnt = (CFG_REPEAT==0) ? 1 : CFG_REPEAT. Go to LOAD.
- LOAD: register SIGNAL_TYPE/T_IMPULSE from the working registers; go to ARM. Both outputs stay stable until the next LOAD.
- ARM: at an edge with ENABLE && OUT_REG_READY, set SIGN_START_GEN<=1, clear the timeout counter and go to WAIT_ACK. Otherwise hold.
- Latency: from the CFG_WR edge (FIFO empty, IDLE, ready) to SIGN_START_GEN=1 is exactly 3 cycles.
- WAIT_ACK: SIGN_START_GEN is held at 1 and the timeout counter increments each cycle.
  - SIGN_START_CALC=1: SIGN_START_GEN<=0, go to RUN.
  - SIGN_START_CALC and SIGN_STOP_CALC both 1 in the same cycle: treat as completion (same as the RUN exit).
  - Counter reaches _ACK_TIMEOUT with no ack: SIGN_START_GEN<=0, ERR_TIMEOUT<=1, discard the remaining repeats and go to IDLE.
- RUN: no timeout. When SIGN_STOP_CALC is sampled high:
  - PULSE_DONE=1 on the next cycle, for exactly 1 cycle.
  - rep_cnt decrements.
  - Load gap_cnt=CFG_GAP of the working descriptor and go to GAP.
- GAP: lasts gap+1 cycles. The minimum of 1 cycle guarantees the generator has released busy. Then go to ARM if rep_cnt!=0, else IDLE. A gap of 0xFFFF must not overflow.
- ENABLE low: gates only the IDLE exit and ARM firing. An in-flight pulse and its gap complete; the descriptor waits in ARM with remaining repeats preserved.
- Stray handshakes: SIGN_START_CALC/SIGN_STOP_CALC in IDLE, LOAD, ARM or GAP are ignored.
- BUSY is combinational from state (0 only in IDLE).
- CFG_FULL is registered from the count.

Test Plan:
- Reset, push {type=3, T=60, gap=0, repeat=1}, ready=1, model acks 2 cycles after start and stop 10 cycles later -> SIGN_START_GEN high 3 cycles after write, held 2 cycles; PULSE_DONE one strobe; BUSY returns 0; SIGNAL_TYPE=3, T_IMPULSE=60.
- repeat=3, gap=5 -> three SIGN_START_GEN assertions; each rising edge is 6 cycles after the preceding PULSE_DONE-1 cycle; exactly 3 PULSE_DONE; then IDLE.
- No ack model, _ACK_TIMEOUT=255 -> SIGN_START_GEN drops after 255 cycles; ERR_TIMEOUT=1 and stays 1; the next queued descriptor still runs; reset clears ERR_TIMEOUT.
- Push 5 descriptors with ENABLE=0 -> CFG_FULL=1 after 4; 5th dropped; enable -> exactly 4 descriptors execute in order, types 0,1,2,3.
- OUT_REG_READY=0 for 20 cycles in ARM, then 1 -> no SIGN_START_GEN until ready; asserted the cycle after ready is sampled.
- Assert RESET=0 during RUN and during WAIT_ACK -> all outputs 0 at that edge, FIFO empty, BUSY=0; recovery after release matches scenario 1.
